// File: rtl/tlc_pkg.sv
// rtl/tlc_pkg.sv - shared signal-head light encoding
// Encoding 2'd3 is intentionally left unnamed; the monitor treats it as a bad encoding.
package tlc_pkg;
  typedef enum logic [1:0] {
    RED = 2'd0,
    YEL = 2'd1,
    GRN = 2'd2
  } light_t;
endpackage

// File: rtl/tlc_conflict_monitor.sv
// rtl/tlc_conflict_monitor.sv - independent NS/EW head conflict, sequence, dwell and watchdog monitor
// Latches the first fault, requests flash, and counts completed legal cycles.
module tlc_conflict_monitor #(
  parameter int MIN_G  = 50,
  parameter int MIN_Y  = 10,
  parameter int MIN_AR = 5,
  parameter int WDOG   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  tlc_pkg::light_t  NS_light,
  input  tlc_pkg::light_t  EW_light,
  input  logic             clear_fault,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             flash_en,
  output logic [2:0]       phase,
  output logic [15:0]      cycles_ok
);
  import tlc_pkg::*;

  localparam int DW = $clog2(WDOG + 1);
  localparam logic [DW-1:0] WDOG_M1 = DW'(WDOG - 1);

  typedef enum logic [2:0] {
    S_NSG   = 3'd0,
    S_NSY   = 3'd1,
    S_AR1   = 3'd2,
    S_EWG   = 3'd3,
    S_EWY   = 3'd4,
    S_AR2   = 3'd5,
    S_FAULT = 3'd6,
    S_SYNC  = 3'd7
  } state_t;

  // Raw pair class; RED/RED is one class and AR1/AR2 is decided by the current state.
  typedef enum logic [2:0] {
    C_NSG, C_NSY, C_RR, C_EWG, C_EWY, C_CONF, C_BAD
  } cls_t;

  state_t         state_q, state_d;
  logic [DW-1:0]  dwell_q, dwell_d;
  logic           first_q, first_d;
  logic           fault_d;
  logic [2:0]     code_d;
  logic [2:0]     latch_code;
  logic           cyc_inc;
  cls_t           cls;
  state_t         cur;
  logic           ns_ok, ew_ok;

  function automatic cls_t state_cls(input state_t s);
    case (s)
      S_NSG:   return C_NSG;
      S_NSY:   return C_NSY;
      S_EWG:   return C_EWG;
      S_EWY:   return C_EWY;
      S_AR1,
      S_AR2:   return C_RR;
      default: return C_BAD;
    endcase
  endfunction

  function automatic state_t succ(input state_t s);
    case (s)
      S_NSG:   return S_NSY;
      S_NSY:   return S_AR1;
      S_AR1:   return S_EWG;
      S_EWG:   return S_EWY;
      S_EWY:   return S_AR2;
      S_AR2:   return S_NSG;
      default: return S_SYNC;
    endcase
  endfunction

  function automatic logic [DW-1:0] min_dwell(input state_t s);
    case (s)
      S_NSG, S_EWG: return DW'(MIN_G);
      S_NSY, S_EWY: return DW'(MIN_Y);
      default:      return DW'(MIN_AR);
    endcase
  endfunction

  assign ns_ok = (NS_light == RED) || (NS_light == YEL) || (NS_light == GRN);
  assign ew_ok = (EW_light == RED) || (EW_light == YEL) || (EW_light == GRN);

  always_comb begin
    cls = C_BAD;
    if (NS_light != RED && EW_light != RED) cls = C_CONF;
    else if (!ns_ok || !ew_ok)              cls = C_BAD;
    else if (NS_light == GRN)               cls = C_NSG;
    else if (NS_light == YEL)               cls = C_NSY;
    else if (EW_light == GRN)               cls = C_EWG;
    else if (EW_light == YEL)               cls = C_EWY;
    else                                    cls = C_RR;
  end

  always_comb begin
    state_d    = state_q;
    dwell_d    = dwell_q;
    first_d    = first_q;
    fault_d    = fault;
    code_d     = fault_code;
    latch_code = 3'd0;
    cyc_inc    = 1'b0;
    cur        = clear_fault ? S_SYNC : state_q;

    if (clear_fault) begin
      fault_d = 1'b0;
      code_d  = 3'd0;
      state_d = S_SYNC;
      dwell_d = '0;
    end

    if (cur != S_FAULT) begin
      if (cls == C_CONF) begin
        latch_code = 3'd1;
      end else if (cls == C_BAD) begin
        latch_code = 3'd2;
      end else if (cur == S_SYNC) begin
        dwell_d = '0;
        first_d = 1'b0;
        if (cls == C_NSG) begin
          state_d = S_NSG;
          dwell_d = DW'(1);
          first_d = 1'b1;
        end else if (cls == C_EWG) begin
          state_d = S_EWG;
          dwell_d = DW'(1);
          first_d = 1'b1;
        end
      end else if (cls == state_cls(cur)) begin
        if (dwell_q >= WDOG_M1) begin
          latch_code = 3'd5;
          dwell_d    = DW'(WDOG);
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end else if (cls != state_cls(succ(cur))) begin
        latch_code = 3'd3;
      end else if (!first_q && dwell_q < min_dwell(cur)) begin
        latch_code = 3'd4;
      end else begin
        state_d = succ(cur);
        dwell_d = DW'(1);
        first_d = 1'b0;
        cyc_inc = (cur == S_AR2);
      end
    end

    if (latch_code != 3'd0) begin
      state_d = S_FAULT;
      fault_d = 1'b1;
      code_d  = latch_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_SYNC;
      dwell_q    <= '0;
      first_q    <= 1'b0;
      fault      <= 1'b0;
      flash_en   <= 1'b0;
      fault_code <= 3'd0;
      phase      <= 3'd7;
      cycles_ok  <= 16'd0;
    end else begin
      state_q    <= state_d;
      dwell_q    <= dwell_d;
      first_q    <= first_d;
      fault      <= fault_d;
      flash_en   <= fault_d;
      fault_code <= code_d;
      phase      <= (state_d == S_FAULT) ? 3'd7 : state_d;
      if (cyc_inc) cycles_ok <= cycles_ok + 16'd1;
    end
  end

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// tb/tb_tlc_conflict_monitor.sv - directed and randomized bench for tlc_conflict_monitor
// Reference model walks a phase table and applies the light-pair rules directly.
module tb_tlc_conflict_monitor;
  import tlc_pkg::*;

  localparam int MIN_G = 50, MIN_Y = 10, MIN_AR = 5, WDOG = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  light_t      ns_l = RED;
  light_t      ew_l = RED;
  logic        clear_fault = 1'b0;
  logic        fault;
  logic [2:0]  fault_code;
  logic        flash_en;
  logic [2:0]  phase;
  logic [15:0] cycles_ok;

  int checks = 0;
  int errors = 0;

  // Phase table: NS head, EW head, minimum dwell, indexed by phase number 0..5.
  int seq_ns [6] = '{2, 1, 0, 0, 0, 0};
  int seq_ew [6] = '{0, 0, 0, 2, 1, 0};
  int mins   [6] = '{MIN_G, MIN_Y, MIN_AR, MIN_G, MIN_Y, MIN_AR};

  bit m_fault;
  bit m_first;
  int m_code, m_phase, m_dwell, m_cycles;
  int wp, r;

  always #5 clk = ~clk;

  tlc_conflict_monitor #(.MIN_G(MIN_G), .MIN_Y(MIN_Y), .MIN_AR(MIN_AR), .WDOG(WDOG)) dut (
    .clk(clk), .rst_n(rst_n), .NS_light(ns_l), .EW_light(ew_l), .clear_fault(clear_fault),
    .fault(fault), .fault_code(fault_code), .flash_en(flash_en), .phase(phase), .cycles_ok(cycles_ok)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_fault = 0; m_first = 0; m_code = 0; m_phase = 7; m_dwell = 0; m_cycles = 0;
  endfunction

  function automatic void latch(input int c);
    if (!m_fault) begin
      m_fault = 1; m_code = c; m_phase = 7;
    end
  endfunction

  function automatic void model_step(input int ns, input int ew, input bit clr);
    int nxt;
    if (clr) begin
      m_fault = 0; m_code = 0; m_phase = 7; m_dwell = 0;
    end
    if (m_fault) return;
    if (ns != 0 && ew != 0) begin latch(1); return; end
    if (ns > 2 || ew > 2) begin latch(2); return; end
    if (m_phase == 7) begin
      if (ns == 2 && ew == 0) begin m_phase = 0; m_dwell = 1; m_first = 1; end
      if (ns == 0 && ew == 2) begin m_phase = 3; m_dwell = 1; m_first = 1; end
      return;
    end
    if (ns == seq_ns[m_phase] && ew == seq_ew[m_phase]) begin
      m_dwell++;
      if (m_dwell >= WDOG) latch(5);
      return;
    end
    nxt = (m_phase + 1) % 6;
    if (ns != seq_ns[nxt] || ew != seq_ew[nxt]) latch(3);
    else if (!m_first && m_dwell < mins[m_phase]) latch(4);
    else begin
      if (m_phase == 5) m_cycles = (m_cycles + 1) & 16'hFFFF;
      m_phase = nxt; m_dwell = 1; m_first = 0;
    end
  endfunction

  task automatic cyc(input int ns, input int ew, input bit clr = 1'b0);
    logic [31:0] expv;
    ns_l = light_t'(2'(ns));
    ew_l = light_t'(2'(ew));
    clear_fault = clr;
    @(posedge clk);
    model_step(ns, ew, clr);
    #1;
    expv = {8'd0, m_fault, m_code[2:0], m_fault, m_phase[2:0], m_cycles[15:0]};
    chk("cycle", {8'd0, fault, fault_code, flash_en, phase, cycles_ok}, expv);
    clear_fault = 1'b0;
  endtask

  task automatic hold(input int p, input int n);
    repeat (n) cyc(seq_ns[p], seq_ew[p]);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fault", fault, 0);
    chk("reset_code", fault_code, 0);
    chk("reset_flash", flash_en, 0);
    chk("reset_phase", phase, 7);
    chk("reset_cycles", cycles_ok, 0);
    rst_n = 1'b1;

    // Legal run: three full cycles, then the NS_G that completes the third.
    for (int c = 0; c < 3; c++)
      for (int p = 0; p < 6; p++) begin
        hold(p, mins[p]);
        chk("legal_phase", phase, p);
      end
    cyc(2, 0);
    chk("legal_cycles", cycles_ok, 3);
    chk("legal_fault", fault, 0);

    // Conflict mid-EW_G.
    hold(0, 49); hold(1, 10); hold(2, 5); hold(3, 20);
    cyc(2, 1);
    chk("conf_fault", fault, 1);
    chk("conf_code", fault_code, 1);
    chk("conf_flash", flash_en, 1);
    chk("conf_phase", phase, 7);

    // Short yellow (9) then legal yellow (10).
    cyc(2, 0, 1); hold(0, 49); hold(1, 9); cyc(0, 0);
    chk("short_code", fault_code, 4);
    cyc(2, 0, 1); hold(0, 49); hold(1, 10); cyc(0, 0);
    chk("yel10_fault", fault, 0);
    chk("yel10_phase", phase, 2);

    // Green straight to red/red, then clear and resync on EW_G.
    cyc(2, 0, 1); hold(0, 59); cyc(0, 0);
    chk("badseq_code", fault_code, 3);
    cyc(0, 0, 1);
    cyc(0, 2);
    chk("resync_phase", phase, 3);
    chk("resync_fault", fault, 0);

    // Watchdog at 255 samples of one phase.
    cyc(2, 0, 1); hold(0, 253);
    chk("wdog_pre", fault, 0);
    cyc(2, 0);
    chk("wdog_code", fault_code, 5);

    // Short dwell plus conflict on the same edge: conflict wins.
    cyc(2, 0, 1); hold(0, 49); hold(1, 3); cyc(2, 2);
    chk("prio_code", fault_code, 1);

    // Bad encoding.
    cyc(0, 0, 1); cyc(0, 3);
    chk("enc_code", fault_code, 2);

    // Asynchronous reset during a latched short-dwell fault.
    cyc(2, 0, 1); hold(0, 49); hold(1, 5); cyc(0, 0);
    chk("rst_pre_code", fault_code, 4);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_fault", fault, 0);
    chk("rst_code", fault_code, 0);
    chk("rst_flash", flash_en, 0);
    chk("rst_phase", phase, 7);
    chk("rst_cycles", cycles_ok, 0);
    @(negedge clk) rst_n = 1'b1;
    hold(1, 20);
    chk("rst_sync_hold", phase, 7);
    cyc(0, 0); hold(3, 3);
    chk("rst_resync", phase, 3);
    cyc(0, 0);
    chk("rst_checks_on", fault_code, 3);

    // Randomized walk with dwell jitter around minimums, glitches and clears.
    wp = 0;
    for (int it = 0; it < 150; it++) begin
      r = int'($urandom_range(0, 19));
      if (m_fault && $urandom_range(0, 2) == 0) begin
        wp = ($urandom_range(0, 1) == 0) ? 0 : 3;
        cyc(seq_ns[wp], seq_ew[wp], 1);
      end else if (r == 0) begin
        cyc(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end else if (r == 1) begin
        cyc(seq_ns[wp], seq_ew[wp], 1);
      end else begin
        hold(wp, int'($urandom_range(mins[wp] - 2, mins[wp] + 4)));
        wp = (wp + 1) % 6;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
